// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the nibble-serial memory bus responder: message codes,
// field widths and the receive/transmit state encodings.
package mem_bus_responder_pkg;

    localparam int unsigned MSG_TYPE_BITS = 2;
    localparam int unsigned NIBBLE_BITS   = 4;
    localparam int unsigned BYTE_BITS     = 8;

    typedef enum logic [MSG_TYPE_BITS-1:0] {
        MSG_NOP   = 2'd0,
        MSG_READ  = 2'd1,
        MSG_WRITE = 2'd2,
        MSG_FETCH = 2'd3
    } msg_type_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxAddr,
        RxData,
        RxIssue
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxWait,
        TxLo,
        TxHi
    } tx_state_e;

    // A header starts a message only if its reserved bits are clear and it is not a NOP.
    function automatic logic header_valid(input logic [NIBBLE_BITS-1:0] nib);
        return (nib[NIBBLE_BITS-1:MSG_TYPE_BITS] == '0) &&
               (msg_type_e'(nib[MSG_TYPE_BITS-1:0]) != MSG_NOP);
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU-side nibble bus: request nibbles from the CPU, response nibbles back to it.
interface mem_bus_responder_if;
    import mem_bus_responder_pkg::*;

    logic                   req_valid;
    logic [NIBBLE_BITS-1:0] req_nibble;
    logic                   rsp_valid;
    logic [NIBBLE_BITS-1:0] rsp_nibble;

    // CPU side
    modport master (
        output req_valid,
        output req_nibble,
        input  rsp_valid,
        input  rsp_nibble
    );

    // Memory-side responder
    modport slave (
        input  req_valid,
        input  req_nibble,
        output rsp_valid,
        output rsp_nibble
    );

endinterface

// File: rtl/mem_bus_rsp_tx.sv
// Transmit side: one-entry response buffer, start delay, LO/HI nibble sequencing and
// sticky overflow when a read result arrives while the buffer still holds unsent data.
module mem_bus_rsp_tx
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned RSP_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic [BYTE_BITS-1:0]   cap_data,
    output logic                   rsp_valid,
    output logic [NIBBLE_BITS-1:0] rsp_nibble,
    output logic                   pending,
    output logic                   overflow
);

    // WAIT is entered with the count of remaining extra cycles minus one.
    localparam logic [3:0] WAIT_INIT = (RSP_DELAY == 0) ? 4'd0 : 4'(RSP_DELAY - 1);

    tx_state_e            state;
    logic [BYTE_BITS-1:0] rsp_byte;
    logic                 full;
    logic [3:0]           wait_cnt;
    logic                 accept;

    // Buffer can take a new byte when empty, or in the HI cycle as it drains.
    always_comb begin
        accept = capture && (!full || (state == TxHi));
    end

    // Transmit FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TxIdle;
            rsp_byte   <= '0;
            full       <= 1'b0;
            wait_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_nibble <= '0;
            overflow   <= 1'b0;
        end else begin
            if (capture && !accept) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                rsp_byte <= cap_data;
                full     <= 1'b1;
                if (RSP_DELAY == 0) begin
                    state      <= TxLo;
                    rsp_valid  <= 1'b1;
                    rsp_nibble <= cap_data[3:0];
                end else begin
                    state      <= TxWait;
                    wait_cnt   <= WAIT_INIT;
                    rsp_valid  <= 1'b0;
                    rsp_nibble <= '0;
                end
            end else begin
                case (state)
                    TxIdle: state <= TxIdle;
                    TxWait: begin
                        if (wait_cnt == 4'd0) begin
                            state      <= TxLo;
                            rsp_valid  <= 1'b1;
                            rsp_nibble <= rsp_byte[3:0];
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    TxLo: begin
                        state      <= TxHi;
                        rsp_nibble <= rsp_byte[7:4];
                    end
                    TxHi: begin
                        state      <= TxIdle;
                        full       <= 1'b0;
                        rsp_valid  <= 1'b0;
                        rsp_nibble <= '0;
                    end
                    default: state <= TxIdle;
                endcase
            end
        end
    end

    assign pending = full;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side end of the nibble-serial bus: decodes request messages, drives a simple
// synchronous memory port and hands read data to the transmit side.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned RSP_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_bus_responder_if.slave    bus,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [BYTE_BITS-1:0]  mem_wdata,
    input  logic [BYTE_BITS-1:0]  mem_rdata,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned ADDR_NIBBLES = ADDR_BITS / NIBBLE_BITS;
    localparam logic [7:0]  LAST_ADDR    = 8'(ADDR_NIBBLES - 1);

    rx_state_e                       rx_state;
    logic                            rx_write;
    logic [7:0]                      nib_cnt;
    logic [ADDR_BITS-1:0]            addr_sr;
    logic [NIBBLE_BITS-1:0]          data_lo;
    logic [ADDR_BITS+NIBBLE_BITS-1:0] addr_cat;
    logic [ADDR_BITS-1:0]            addr_next;
    logic                            rd_pend;
    logic                            tx_rsp_valid;
    logic [NIBBLE_BITS-1:0]          tx_rsp_nibble;
    logic                            tx_pending;

    // Address arrives LS nibble first, so each new nibble enters at the top and shifts down.
    always_comb begin
        addr_cat  = {bus.req_nibble, addr_sr};
        addr_next = addr_cat[ADDR_BITS+NIBBLE_BITS-1:NIBBLE_BITS];
    end

    // Receive FSM with registered memory strobes; strobes are high only in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RxIdle;
            rx_write  <= 1'b0;
            nib_cnt   <= '0;
            addr_sr   <= '0;
            data_lo   <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (rx_state)
                RxIdle: begin
                    if (bus.req_valid && header_valid(bus.req_nibble)) begin
                        rx_write <= (msg_type_e'(bus.req_nibble[1:0]) == MSG_WRITE);
                        nib_cnt  <= '0;
                        rx_state <= RxAddr;
                    end
                end
                RxAddr: begin
                    if (bus.req_valid) begin
                        addr_sr <= addr_next;
                        if (nib_cnt == LAST_ADDR) begin
                            nib_cnt <= '0;
                            if (rx_write) begin
                                rx_state <= RxData;
                            end else begin
                                rx_state <= RxIssue;
                                mem_addr <= addr_next;
                                mem_re   <= 1'b1;
                            end
                        end else begin
                            nib_cnt <= nib_cnt + 8'd1;
                        end
                    end
                end
                RxData: begin
                    if (bus.req_valid) begin
                        if (nib_cnt == 8'd0) begin
                            data_lo <= bus.req_nibble;
                            nib_cnt <= 8'd1;
                        end else begin
                            rx_state  <= RxIssue;
                            mem_addr  <= addr_sr;
                            mem_we    <= 1'b1;
                            mem_wdata <= {bus.req_nibble, data_lo};
                        end
                    end
                end
                RxIssue: rx_state <= RxIdle;
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // Read data is valid the cycle after the strobe; mark that cycle for capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= mem_re;
        end
    end

    mem_bus_rsp_tx #(
        .RSP_DELAY (RSP_DELAY)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (rd_pend),
        .cap_data   (mem_rdata),
        .rsp_valid  (tx_rsp_valid),
        .rsp_nibble (tx_rsp_nibble),
        .pending    (tx_pending),
        .overflow   (overflow)
    );

    assign bus.rsp_valid  = tx_rsp_valid;
    assign bus.rsp_nibble = tx_rsp_nibble;

    // A read between ISSUE and capture still counts as a pending response.
    assign busy = (rx_state != RxIdle) || rd_pend || tx_pending;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: four instances with different response delays share one
// request stream; expected strobes and response nibbles are queued as requests are sent.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    localparam int unsigned NUM_DUT = 4;
    localparam int unsigned AB      = 16;

    typedef struct {
        int         cyc;
        logic [3:0] nib;
    } rsp_exp_t;

    typedef struct {
        int          cyc;
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } strobe_exp_t;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        req_valid  = 1'b0;
    logic [3:0]  req_nibble = 4'd0;
    logic        expect_idle = 1'b0;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          dly[NUM_DUT] = '{1, 15, 0, 4};
    int          hi_last[NUM_DUT];
    logic        ovf_exp[NUM_DUT];
    logic [NUM_DUT-1:0] ovf_obs;
    rsp_exp_t    rsp_q[NUM_DUT][$];
    strobe_exp_t str_q[NUM_DUT][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rd_fn(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h0D;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 15 : (g == 2) ? 0 : 4;

        mem_bus_responder_if bus_if ();

        logic [AB-1:0] mem_addr;
        logic          mem_re;
        logic          mem_we;
        logic [7:0]    mem_wdata;
        logic [7:0]    mem_rdata;
        logic          busy;
        logic          overflow;

        assign bus_if.req_valid  = req_valid;
        assign bus_if.req_nibble = req_nibble;
        assign ovf_obs[g]        = overflow;

        mem_bus_responder #(
            .ADDR_BITS (AB),
            .RSP_DELAY (D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .bus       (bus_if),
            .mem_addr  (mem_addr),
            .mem_re    (mem_re),
            .mem_we    (mem_we),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .busy      (busy),
            .overflow  (overflow)
        );

        // Synchronous memory: data valid only the cycle after a read strobe, noise otherwise.
        always @(posedge clk) begin
            mem_rdata <= mem_re ? rd_fn(mem_addr) : 8'($urandom);
        end

        always @(negedge clk) begin : mon
            logic        exp_v;
            logic [3:0]  exp_n;
            logic        exp_s;
            strobe_exp_t s;
            if (!rst_n) begin
                check($sformatf("reset_outputs[%0d]", g),
                      32'({bus_if.rsp_valid, bus_if.rsp_nibble, mem_re, mem_we, mem_wdata,
                           busy, overflow}), 32'd0);
                check($sformatf("reset_addr[%0d]", g), 32'(mem_addr), 32'd0);
            end else begin
                exp_v = (rsp_q[g].size() > 0) && (rsp_q[g][0].cyc == cyc);
                exp_n = exp_v ? rsp_q[g][0].nib : 4'd0;
                check($sformatf("rsp_valid[%0d]", g), 32'(bus_if.rsp_valid), 32'(exp_v));
                check($sformatf("rsp_nibble[%0d]", g), 32'(bus_if.rsp_nibble), 32'(exp_n));
                if (exp_v) void'(rsp_q[g].pop_front());
                exp_s = (str_q[g].size() > 0) && (str_q[g][0].cyc == cyc);
                if (exp_s) begin
                    s = str_q[g].pop_front();
                end else begin
                    s.cyc = cyc; s.re = 1'b0; s.we = 1'b0; s.addr = '0; s.wdata = '0;
                end
                check($sformatf("mem_re[%0d]", g), 32'(mem_re), 32'(s.re));
                check($sformatf("mem_we[%0d]", g), 32'(mem_we), 32'(s.we));
                if (exp_s) check($sformatf("mem_addr[%0d]", g), 32'(mem_addr), 32'(s.addr));
                if (exp_s && s.we) begin
                    check($sformatf("mem_wdata[%0d]", g), 32'(mem_wdata), 32'(s.wdata));
                end
                if (expect_idle) check($sformatf("busy_idle[%0d]", g), 32'(busy), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] n);
        tick();
        req_valid  = 1'b1;
        req_nibble = n;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            tick();
            req_valid  = 1'b0;
            req_nibble = 4'd0;
        end
    endtask

    // Last address nibble in cycle t: strobe at t+1, capture at end of t+2.
    task automatic expect_read(input int t, input logic [15:0] a);
        int          c;
        logic [7:0]  b;
        rsp_exp_t    e;
        strobe_exp_t s;
        c = t + 2;
        b = rd_fn(a);
        for (int i = 0; i < NUM_DUT; i++) begin
            s.cyc = t + 1; s.re = 1'b1; s.we = 1'b0; s.addr = a; s.wdata = 8'd0;
            str_q[i].push_back(s);
            if (c >= hi_last[i]) begin
                e.cyc = c + 1 + dly[i]; e.nib = b[3:0];
                rsp_q[i].push_back(e);
                e.cyc = c + 2 + dly[i]; e.nib = b[7:4];
                rsp_q[i].push_back(e);
                hi_last[i] = c + 2 + dly[i];
            end else begin
                ovf_exp[i] = 1'b1;
            end
        end
    endtask

    task automatic send_read(input logic [1:0] typ, input logic [15:0] a,
                             input int stall_at, input int stall_len);
        send({2'b00, typ});
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) idle(stall_len);
            send(a[4*i +: 4]);
        end
        expect_read(cyc, a);
        idle(1);
    endtask

    task automatic send_write(input logic [15:0] a, input logic [7:0] d);
        strobe_exp_t s;
        send({2'b00, MSG_WRITE});
        for (int i = 0; i < 4; i++) send(a[4*i +: 4]);
        send(d[3:0]);
        send(d[7:4]);
        for (int i = 0; i < NUM_DUT; i++) begin
            s.cyc = cyc + 1; s.re = 1'b0; s.we = 1'b1; s.addr = a; s.wdata = d;
            str_q[i].push_back(s);
        end
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NUM_DUT; i++) begin
            hi_last[i] = 0;
            ovf_exp[i] = 1'b0;
        end
        rst_n = 1'b0;
        idle(4);
        rst_n = 1'b1;
        idle(2);

        // Reset in the middle of an address must abort without a strobe.
        send(4'h1);
        send(4'hF);
        send(4'hE);
        tick();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        send_read(MSG_READ, 16'hBEEF, -1, 0);
        idle(25);

        send_write(16'h1234, 8'hAD);
        idle(3);
        send_read(MSG_READ, 16'hBEEF, -1, 0);
        idle(25);
        send_read(MSG_READ, 16'h1357, 2, 3);
        idle(25);

        // NOP and reserved-bit headers are ignored.
        expect_idle = 1'b1;
        send(4'h0);
        send(4'h5);
        send(4'hC);
        idle(4);
        expect_idle = 1'b0;

        // Back-to-back reads: long delay overflows, delay 4 captures in the HI cycle.
        send_read(MSG_FETCH, 16'hA0A0, -1, 0);
        send_read(MSG_READ, 16'h0F1E, -1, 0);
        idle(30);

        send_read(MSG_READ, 16'h4242, -1, 0);
        send_write(16'h0011, 8'h99);
        send_read(MSG_FETCH, 16'hCAFE, -1, 0);
        idle(40);

        for (int i = 0; i < NUM_DUT; i++) begin
            check($sformatf("rsp_left[%0d]", i), 32'(rsp_q[i].size()), 32'd0);
            check($sformatf("strobe_left[%0d]", i), 32'(str_q[i].size()), 32'd0);
            check($sformatf("overflow[%0d]", i), 32'(ovf_obs[i]), 32'(ovf_exp[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
